dec_scan: RTL and testbench

Parametrised, registered AW-to-2^AW one-hot decoder with enable and an optional auto-scan mode. In scan mode it walks the one-hot select through every output, holding each for a programmable dwell with blanking gaps, like a multiplexed display digit driver. It is the clocked, generalised successor to the team's fixed 2-to-4 enable decoder, and sits between control logic and shared-bus or display select lines.

---
 rtl/dec_scan_if.sv | 25 ++
 rtl/dec_scan.sv | 150 +++++++++++++++
 tb/tb_dec_scan.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/dec_scan_if.sv
// Select-bus interface for dec_scan: control inputs from the sequencer,
// registered one-hot select and status back from the decoder.
interface dec_scan_if #(
   parameter int AW      = 2,
   parameter int DWELL_W = 8
);
   logic                 en;
   logic                 mode;
   logic [AW-1:0]        a;
   logic [DWELL_W-1:0]   dwell;
   logic [(1<<AW)-1:0]   y;
   logic [AW-1:0]        idx;
   logic                 valid;
   logic                 wrap;

   modport master (
      output en, mode, a, dwell,
      input  y, idx, valid, wrap
   );

   modport slave (
      input  en, mode, a, dwell,
      output y, idx, valid, wrap
   );
endinterface

// File: rtl/dec_scan.sv
// dec_scan: registered AW-to-2^AW one-hot decoder with enable.
// Optional auto-scan (build macro DEC_SCAN_EN) walks the select through every
// output, holding each for dwell+1 cycles with BLANK all-zero gap cycles.
// Without DEC_SCAN_EN the block is a plain registered decoder; mode/dwell are
// ignored and wrap stays 0.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | direct decode or disabled; scan counters cleared
// ST_DRIVE | scan: y = 1<<idx, dwell counter counting down to 0
// ST_BLANK | scan: y = 0 for BLANK cycles, idx held
module dec_scan #(
   parameter int AW      = 2,
   parameter int DWELL_W = 8,
   parameter int BLANK   = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   dec_scan_if.slave  bus
);

   localparam int NY = 1 << AW;

   function automatic logic [NY-1:0] onehot(input logic [AW-1:0] i);
      onehot    = '0;
      onehot[i] = 1'b1;
   endfunction

`ifdef DEC_SCAN_EN

   // Blank counter runs from BLANK-1 down to 0.
   localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_BLANK = 2'd2
   } state_t;

   state_t              state;
   logic [DWELL_W-1:0]  cnt;
   logic [BW-1:0]       bcnt;
   logic [AW-1:0]       idx_nxt;

   assign idx_nxt = bus.idx + 1'b1;

   // Decoder / scan sequencer; en=0 overrides everything but reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         bcnt      <= '0;
         bus.y     <= '0;
         bus.idx   <= '0;
         bus.valid <= 1'b0;
         bus.wrap  <= 1'b0;
      end else if (!bus.en) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         bcnt      <= '0;
         bus.y     <= '0;
         bus.valid <= 1'b0;
         bus.wrap  <= 1'b0;
      end else if (!bus.mode) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         bcnt      <= '0;
         bus.y     <= onehot(bus.a);
         bus.idx   <= bus.a;
         bus.valid <= 1'b1;
         bus.wrap  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               // scan always starts at index 0, no wrap pulse on entry
               state     <= ST_DRIVE;
               cnt       <= bus.dwell;
               bus.idx   <= '0;
               bus.y     <= onehot('0);
               bus.valid <= 1'b1;
               bus.wrap  <= 1'b0;
            end
            ST_DRIVE: begin
               bus.wrap <= 1'b0;
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (BLANK > 0) begin
                  state     <= ST_BLANK;
                  bcnt      <= BW'((BLANK > 0) ? BLANK - 1 : 0);
                  bus.y     <= '0;
                  bus.valid <= 1'b0;
               end else begin
                  state     <= ST_DRIVE;
                  cnt       <= bus.dwell;
                  bus.idx   <= idx_nxt;
                  bus.y     <= onehot(idx_nxt);
                  bus.valid <= 1'b1;
                  bus.wrap  <= (idx_nxt == '0);
               end
            end
            ST_BLANK: begin
               if (bcnt != '0) begin
                  bcnt <= bcnt - 1'b1;
               end else begin
                  state     <= ST_DRIVE;
                  cnt       <= bus.dwell;
                  bus.idx   <= idx_nxt;
                  bus.y     <= onehot(idx_nxt);
                  bus.valid <= 1'b1;
                  bus.wrap  <= (idx_nxt == '0);
               end
            end
            default: begin
               state     <= ST_IDLE;
               bus.y     <= '0;
               bus.valid <= 1'b0;
               bus.wrap  <= 1'b0;
            end
         endcase
      end
   end

`else

   // Scan hardware not built: mode and dwell have no effect.
   logic unused_scan_inputs;
   assign unused_scan_inputs = ^{bus.mode, bus.dwell};

   // Plain registered decoder; idx holds while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.y     <= '0;
         bus.idx   <= '0;
         bus.valid <= 1'b0;
         bus.wrap  <= 1'b0;
      end else if (!bus.en) begin
         bus.y     <= '0;
         bus.valid <= 1'b0;
         bus.wrap  <= 1'b0;
      end else begin
         bus.y     <= onehot(bus.a);
         bus.idx   <= bus.a;
         bus.valid <= 1'b1;
         bus.wrap  <= 1'b0;
      end
   end

`endif

endmodule

// File: tb/tb_dec_scan.sv
// Scoreboard bench for dec_scan: two instances (BLANK=1 and BLANK=0) share
// stimulus; expected outputs come from an arithmetic scan-schedule model.
module tb_dec_scan;

   localparam int AW = 2;
   localparam int DW = 8;
   localparam int NY = 1 << AW;
`ifdef DEC_SCAN_EN
   localparam bit SCAN = 1'b1;
`else
   localparam bit SCAN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   bit   clk_run = 1'b1;

   always #5 if (clk_run) clk = ~clk;

   dec_scan_if #(.AW(AW), .DWELL_W(DW)) bus0 ();
   dec_scan_if #(.AW(AW), .DWELL_W(DW)) bus1 ();

   dec_scan #(.AW(AW), .DWELL_W(DW), .BLANK(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
   dec_scan #(.AW(AW), .DWELL_W(DW), .BLANK(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   typedef struct packed {
      logic [NY-1:0] y;
      logic [AW-1:0] idx;
      logic          valid;
      logic          wrap;
   } obs_t;

   typedef struct {
      int   due;
      obs_t e;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // reference model state
   bit            m_scan = 1'b0;
   int            m_n    = 0;
   int            m_d    = 0;
   logic [AW-1:0] m_idx [2] = '{default: '0};

   task automatic apply(input bit en, input bit mode, input logic [AW-1:0] a,
                        input logic [DW-1:0] dwell);
      bit   sc;
      obs_t e;
      int   blank, p, step, off, id;
      bus0.en = en; bus0.mode = mode; bus0.a = a; bus0.dwell = dwell;
      bus1.en = en; bus1.mode = mode; bus1.a = a; bus1.dwell = dwell;
      sc = en && mode && SCAN;
      if (!sc) m_scan = 1'b0;
      else if (!m_scan) begin m_scan = 1'b1; m_n = 0; m_d = int'(dwell); end
      else m_n++;
      for (int k = 0; k < 2; k++) begin
         blank = (k == 0) ? 1 : 0;
         e = '0;
         if (!en) begin
            e.idx = m_idx[k];
         end else if (!sc) begin
            e.y[a]   = 1'b1;
            e.idx    = a;
            e.valid  = 1'b1;
            m_idx[k] = a;
         end else begin
            p    = m_d + 1 + blank;
            step = m_n / p;
            off  = m_n % p;
            id   = step % NY;
            e.idx    = AW'(id);
            m_idx[k] = AW'(id);
            if (off <= m_d) begin
               e.y[id] = 1'b1;
               e.valid = 1'b1;
            end
            e.wrap = (off == 0) && (step > 0) && (id == 0);
         end
         if (k == 0) q0.push_back('{due: cyc + 1, e: e});
         else        q1.push_back('{due: cyc + 1, e: e});
      end
   endtask

   task automatic run(input int n, input bit en, input bit mode,
                      input logic [AW-1:0] a, input logic [DW-1:0] dwell);
      repeat (n) begin
         @(posedge clk); #1;
         apply(en, mode, a, dwell);
      end
   endtask

   task automatic check_one(input int k, input obs_t act);
      exp_t ex;
      bit   have = 1'b0;
      if (k == 0) begin
         while (q0.size() > 0 && q0[0].due < cyc) begin
            ex = q0.pop_front(); checks++; errors++;
            $display("FAIL missed0 due=%0d at cyc=%0d", ex.due, cyc);
         end
         if (q0.size() > 0 && q0[0].due == cyc) begin ex = q0.pop_front(); have = 1'b1; end
      end else begin
         while (q1.size() > 0 && q1[0].due < cyc) begin
            ex = q1.pop_front(); checks++; errors++;
            $display("FAIL missed1 due=%0d at cyc=%0d", ex.due, cyc);
         end
         if (q1.size() > 0 && q1[0].due == cyc) begin ex = q1.pop_front(); have = 1'b1; end
      end
      if (have) begin
         checks++;
         if (act !== ex.e) begin
            errors++;
            $display("FAIL out_blank%0d cyc=%0d got y=%b idx=%0d valid=%b wrap=%b, want y=%b idx=%0d valid=%b wrap=%b",
                     1 - k, cyc, act.y, act.idx, act.valid, act.wrap,
                     ex.e.y, ex.e.idx, ex.e.valid, ex.e.wrap);
         end
      end
   endtask

   // monitor: compare each cycle's registered outputs against the scoreboard
   always begin
      @(posedge clk); #3;
      check_one(0, {bus0.y, bus0.idx, bus0.valid, bus0.wrap});
      check_one(1, {bus1.y, bus1.idx, bus1.valid, bus1.wrap});
   end

   task automatic check_zero(input string name);
      obs_t a0, a1;
      a0 = {bus0.y, bus0.idx, bus0.valid, bus0.wrap};
      a1 = {bus1.y, bus1.idx, bus1.valid, bus1.wrap};
      checks += 2;
      if (a0 !== '0) begin errors++; $display("FAIL %s blank1 got %b want 0", name, a0); end
      if (a1 !== '0) begin errors++; $display("FAIL %s blank0 got %b want 0", name, a1); end
   endtask

   initial begin
      logic [DW-1:0] dw;
      logic [AW-1:0] aa;
      bit            en_s, mode_s;
      int            len;

      bus0.en = 0; bus0.mode = 0; bus0.a = '0; bus0.dwell = '0;
      bus1.en = 0; bus1.mode = 0; bus1.a = '0; bus1.dwell = '0;
      repeat (2) @(negedge clk);
      check_zero("reset_init");
      rst_n = 1'b1;

      // direct decode, 20 cycles per address, then disable
      for (int i = 0; i < NY; i++) run(20, 1, 0, AW'(i), 8'd0);
      run(3, 0, 0, 2'd3, 8'd0);

      // scan, dwell=2: two full periods
      run(34, 1, 1, 2'd0, 8'd2);
      run(2, 0, 1, 2'd0, 8'd2);

      // scan, dwell=0
      run(14, 1, 1, 2'd0, 8'd0);
      run(1, 0, 1, 2'd0, 8'd0);

      // abort during idx=2 drive (dwell=1), then restart
      run(7, 1, 1, 2'd0, 8'd1);
      run(2, 0, 1, 2'd0, 8'd1);
      run(5, 1, 1, 2'd0, 8'd1);

      // mode changes while enabled
      run(3, 1, 0, 2'd2, 8'd1);
      run(4, 1, 1, 2'd1, 8'd1);
      run(2, 1, 0, 2'd1, 8'd1);

      // asynchronous reset with the clock stopped
      run(3, 0, 0, 2'd0, 8'd0);
      @(posedge clk); @(posedge clk); #4;
      run(6, 1, 1, 2'd0, 8'd1);
      run(1, 0, 1, 2'd0, 8'd1);
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      clk_run = 1'b0;
      rst_n   = 1'b0;
      #2;
      check_zero("reset_async");
      m_scan = 1'b0;
      m_idx  = '{default: '0};
      #10 clk_run = 1'b1;
      @(negedge clk); rst_n = 1'b1;

      // randomized segments
      dw = 8'd1;
      for (int s = 0; s < 40; s++) begin
         len    = $urandom_range(1, 25);
         en_s   = ($urandom_range(0, 3) != 0);
         mode_s = $urandom_range(0, 1) != 0;
         for (int i = 0; i < len; i++) begin
            aa = AW'($urandom_range(0, NY - 1));
            if (!m_scan) dw = DW'($urandom_range(0, 4));
            @(posedge clk); #1;
            apply(en_s, mode_s, aa, dw);
         end
      end
      run(2, 0, 0, 2'd0, 8'd0);

      repeat (3) @(posedge clk);
      #5;
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL drain q0=%0d q1=%0d want 0", q0.size(), q1.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
